// File: rtl/byte_ram_reader_pkg.sv
// Shared constants and helpers for the byte-lane RAM reader and its response FIFO.
package byte_ram_reader_pkg;

   localparam int DEF_NUM_COL    = 4;
   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_FIFO_DEPTH = 3;
   localparam int LANE_WIDTH     = 8;

   // Width of an index into 'depth' entries; never below one bit.
   function automatic int ptr_width(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO with modulo-DEPTH pointers, so any depth works.
module resp_fifo
   import byte_ram_reader_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int WIDTH = DEF_NUM_COL * LANE_WIDTH,
   localparam int PW   = ptr_width(DEPTH),
   localparam int CW   = ptr_width(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o
);

   localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == DEPTH_CNT);
   assign valid_o = (count_q != '0);
   assign do_pop  = pop_i & valid_o;
   assign do_push = push_i & (~full | do_pop);
   assign count_o = count_q;
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

   // NOTE: every variable driven here gets a default first, otherwise a latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/byte_ram_reader.sv
// Issues word reads to a registered RAM port, patches bytes written in the issue
// cycle, and buffers responses in order behind a valid/ready interface.
module byte_ram_reader
   import byte_ram_reader_pkg::*;
#(
   parameter int NUM_COL    = DEF_NUM_COL,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = NUM_COL * LANE_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  ram_enb,
   output logic [ADDR_WIDTH-1:0] ram_addrb,
   input  logic [DATA_WIDTH-1:0] ram_dob,
   input  logic                  wr_en,
   input  logic [NUM_COL-1:0]    wr_we,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_din,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data
);

   localparam int            CW        = ptr_width(FIFO_DEPTH + 1);
   localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(FIFO_DEPTH);

   logic                  issue;
   logic                  inflight_q, inflight_d;
   logic [NUM_COL-1:0]    merge_we_q, merge_we_d;
   logic [DATA_WIDTH-1:0] merge_din_q, merge_din_d;
   logic [DATA_WIDTH-1:0] merged_data;
   logic [CW-1:0]         fifo_count;
   logic [CW:0]           occupancy;

   // Ready depends only on registered state, never on this cycle's inputs.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
   assign req_ready = (occupancy < DEPTH_SUM);
   assign issue     = req_valid & req_ready & ~reset;
   assign ram_enb   = issue;
   assign ram_addrb = issue ? req_addr : '0;

   // A same-cycle write to the read address is invisible to the RAM's read port,
   // so its byte enables and data are captured now and patched in next cycle.
   always_comb begin
      inflight_d  = issue;
      merge_we_d  = '0;
      merge_din_d = merge_din_q;
      if (issue && wr_en && (wr_addr == req_addr)) begin
         merge_we_d  = wr_we;
         merge_din_d = wr_din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_q  <= 1'b0;
         merge_we_q  <= '0;
         merge_din_q <= '0;
      end else begin
         inflight_q  <= inflight_d;
         merge_we_q  <= merge_we_d;
         merge_din_q <= merge_din_d;
      end
   end

   always_comb begin
      merged_data = ram_dob;
      for (int i = 0; i < NUM_COL; i++) begin
         if (merge_we_q[i]) begin
            merged_data[i*LANE_WIDTH +: LANE_WIDTH] = merge_din_q[i*LANE_WIDTH +: LANE_WIDTH];
         end
      end
   end

   resp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_resp_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (inflight_q),
      .push_data_i (merged_data),
      .pop_i       (resp_ready),
      .valid_o     (resp_valid),
      .data_o      (resp_data),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_byte_ram_reader.sv
// Self-checking bench for byte_ram_reader: vector table, corner sequences and a scoreboard.
module tb_byte_ram_reader;

   localparam int NUM_COL = 4;
   localparam int AW      = 12;
   localparam int DW      = 32;
   localparam int DEPTH   = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          ram_enb;
   logic [AW-1:0] ram_addrb;
   logic [DW-1:0] ram_dob = '0;
   logic          wr_en = 1'b0;
   logic [3:0]    wr_we = '0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_din = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [DW-1:0] resp_data;

   always #5 clk = ~clk;

   byte_ram_reader #(
      .NUM_COL    (NUM_COL),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .ram_enb    (ram_enb),
      .ram_addrb  (ram_addrb),
      .ram_dob    (ram_dob),
      .wr_en      (wr_en),
      .wr_we      (wr_we),
      .wr_addr    (wr_addr),
      .wr_din     (wr_din),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data)
   );

   // Read-first true dual-port RAM: registered read, byte-enabled write.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_enb) ram_dob <= mem[ram_addrb];
      if (wr_en) begin
         for (int i = 0; i < NUM_COL; i++)
            if (wr_we[i]) mem[wr_addr][i*8 +: 8] <= wr_din[i*8 +: 8];
      end
   end

   typedef struct {
      logic [DW-1:0] d;
      int            t;
   } sb_t;

   typedef struct {
      logic          rv;
      logic [AW-1:0] ra;
      logic          wen;
      logic [3:0]    we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          exp_enb;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
   } vec_t;

   sb_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  enb_seen = 0;
   int  resp_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] merged(input logic [AW-1:0] ra, input logic wen,
                                            input logic [3:0] we, input logic [AW-1:0] wa,
                                            input logic [DW-1:0] wd);
      logic [DW-1:0] r;
      r = mem[ra];
      if (wen && wa == ra)
         for (int i = 0; i < NUM_COL; i++)
            if (we[i]) r[i*8 +: 8] = wd[i*8 +: 8];
      return r;
   endfunction

   // One clock: drive at the falling edge, compare against the model before the rising edge.
   task automatic cycle(input logic rv, input logic [AW-1:0] ra, input logic wen,
                        input logic [3:0] we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic rr);
      logic m_ready, m_valid, m_issue;
      @(negedge clk);
      req_valid  = rv;
      req_addr   = ra;
      wr_en      = wen;
      wr_we      = we;
      wr_addr    = wa;
      wr_din     = wd;
      resp_ready = rr;
      #1;
      m_ready = (exp_q.size() < DEPTH);
      m_valid = (exp_q.size() > 0) && (cyc - exp_q[0].t >= 2);
      m_issue = rv && m_ready;
      check("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
      check("resp_valid", {31'b0, resp_valid}, {31'b0, m_valid});
      check("ram_enb", {31'b0, ram_enb}, {31'b0, m_issue});
      if (m_issue) check("ram_addrb", {20'b0, ram_addrb}, {20'b0, ra});
      if (m_valid) check("resp_data", resp_data, exp_q[0].d);
      if (ram_enb) enb_seen++;
      if (resp_valid && resp_ready) resp_seen++;
      if (m_valid && rr) void'(exp_q.pop_front());
      if (m_issue) exp_q.push_back('{merged(ra, wen, we, wa, wd), cyc});
      cyc++;
   endtask

   task automatic idle(input logic rr);
      cycle(1'b0, '0, 1'b0, 4'h0, '0, '0, rr);
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && (exp_q.size() > 0 || resp_valid); c++) idle(1'b1);
      check("drain_idle", {31'b0, resp_valid}, 32'h0);
   endtask

   vec_t tbl[12];

   initial begin
      logic [AW-1:0] pend[$];
      logic [AW-1:0] a;
      for (int i = 0; i < (1 << AW); i++) mem[i] = {8'h5A, 4'h0, 12'(i), 8'hC3};
      mem[12'h010] = 32'hAABBCCDD;

      tbl[0]  = '{1'b1, 12'h010, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 12'h000, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 12'h000, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b1, 32'hAABBCCDD};
      tbl[3]  = '{1'b1, 12'h010, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 32'h0};
      tbl[4]  = '{1'b0, 12'h000, 1'b1, 4'h5, 12'h010, 32'h11223344, 1'b0, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 12'h000, 1'b1, 4'hF, 12'h010, 32'hAABBCCDD, 1'b0, 1'b1, 32'hAABBCCDD};
      tbl[6]  = '{1'b1, 12'h010, 1'b1, 4'h5, 12'h010, 32'h11223344, 1'b1, 1'b0, 32'h0};
      tbl[7]  = '{1'b0, 12'h000, 1'b1, 4'hF, 12'h010, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 12'h000, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b1, 32'hAA22CC44};
      tbl[9]  = '{1'b1, 12'h020, 1'b1, 4'hF, 12'h021, 32'h99887766, 1'b1, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 12'h000, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 12'h000, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b1, 32'h5A0020C3};

      // Reset values.
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_ready", {31'b0, req_ready}, 32'h1);
      check("rst_ram_enb", {31'b0, ram_enb}, 32'h0);
      check("rst_ram_addrb", {20'b0, ram_addrb}, 32'h0);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
      check("rst_resp_data", resp_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Vector table: single read, late write, same-cycle merge, non-matching write.
      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].rv, tbl[i].ra, tbl[i].wen, tbl[i].we, tbl[i].wa, tbl[i].wd, 1'b1);
         check($sformatf("tbl%0d_enb", i), {31'b0, ram_enb}, {31'b0, tbl[i].exp_enb});
         check($sformatf("tbl%0d_valid", i), {31'b0, resp_valid}, {31'b0, tbl[i].exp_valid});
         if (tbl[i].exp_valid) check($sformatf("tbl%0d_data", i), resp_data, tbl[i].exp_data);
      end
      drain();

      // Backpressure: five requests against a stalled consumer.
      for (int i = 0; i < 5; i++) pend.push_back(12'(12'h030 + i));
      enb_seen = 0;
      for (int c = 0; c < 5; c++) begin
         a = pend[0];
         cycle(1'b1, a, 1'b0, 4'h0, '0, '0, 1'b0);
         if (ram_enb) void'(pend.pop_front());
      end
      check("bp_accepted", enb_seen, 3);
      check("bp_ready_low", {31'b0, req_ready}, 32'h0);
      resp_seen = 0;
      for (int c = 0; c < 30 && (pend.size() > 0 || exp_q.size() > 0); c++) begin
         a = (pend.size() > 0) ? pend[0] : '0;
         cycle(pend.size() > 0, a, 1'b0, 4'h0, '0, '0, 1'b1);
         if (ram_enb) void'(pend.pop_front());
      end
      check("bp_responses", resp_seen, 5);
      check("bp_accepted_all", enb_seen, 5);
      drain();

      // Streaming: one request per cycle with the consumer always ready.
      enb_seen = 0;
      resp_seen = 0;
      for (int i = 0; i < 100; i++) cycle(1'b1, 12'(12'h100 + i), 1'b0, 4'h0, '0, '0, 1'b1);
      check("stream_accepted", enb_seen, 100);
      drain();
      check("stream_responses", resp_seen, 100);

      // Random traffic with frequent write hits on the read address.
      for (int i = 0; i < 300; i++) begin
         logic [AW-1:0] ra, wa;
         ra = 12'($urandom_range(0, 15));
         wa = ($urandom_range(0, 1) == 1) ? ra : 12'($urandom_range(0, 15));
         cycle(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), 4'($urandom),
               wa, $urandom, ($urandom_range(0, 3) != 0));
      end
      drain();

      // Reset with two buffered responses and one in flight.
      cycle(1'b1, 12'h040, 1'b0, 4'h0, '0, '0, 1'b0);
      cycle(1'b1, 12'h041, 1'b0, 4'h0, '0, '0, 1'b0);
      cycle(1'b1, 12'h042, 1'b0, 4'h0, '0, '0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      req_valid = 1'b0;
      #1;
      check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
      check("mid_rst_resp_data", resp_data, 32'h0);
      check("mid_rst_req_ready", {31'b0, req_ready}, 32'h1);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      resp_seen = 0;
      repeat (5) idle(1'b1);
      check("post_rst_no_resp", resp_seen, 0);

      // Recovery after reset.
      cycle(1'b1, 12'h010, 1'b0, 4'h0, '0, '0, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
